led_seq_ctl: RTL and testbench

//  Programmable LED pattern sequencer sitting between pifctl and the LED output buffers.
//  - Takes a single-cycle config write strobe decoded from the I2C/wishbone register space.
//  - Times ON/OFF phases from xclk through an internal prescaler.
//  - Drives red/green per the selected colour mode, with finite or continuous repeat.
//  - Replaces the static MiscReg pattern decode with a sequenced, self-timed controller.

---
 rtl/led_seq_ctl_if.sv | 10 +
 rtl/led_seq_ctl.sv | 90 +++++++++
 tb/tb_led_seq_ctl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/led_seq_ctl_if.sv
// led_seq_ctl_if: config write bus from the register decoder into the LED sequencer.
interface led_seq_ctl_if #(
   parameter int DATA_W = 8
);
   logic              cfg_wr;
   logic [1:0]        cfg_addr;
   logic [DATA_W-1:0] cfg_data;
   modport master(output cfg_wr, cfg_addr, cfg_data);
   modport slave(input cfg_wr, cfg_addr, cfg_data);
endinterface

// File: rtl/led_seq_ctl.sv
// led_seq_ctl: self-timed ON/OFF LED pattern sequencer with finite or continuous repeat.
module led_seq_ctl #(
   parameter int PRESCALE_DIV = 1000,
   parameter int PRESCALE_W   = 16,
   parameter int DATA_W       = 8
) (
   input  logic              xclk,
   input  logic              sys_rst,
   led_seq_ctl_if.slave      cfg,
   output logic              led_r,
   output logic              led_g,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rpt_left
);
   typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
   state_t state, state_n;
   logic [1:0] mode, mode_n;
   logic [DATA_W-1:0] on_time, off_time, rpt_reg, phase_cnt, phase_n, rpt_n, on_load, off_load;
   logic [PRESCALE_W-1:0] presc, presc_n;
   logic tick, end_ph, mode_wr, done_n, led_r_n, led_g_n;
   assign mode_wr  = cfg.cfg_wr && cfg.cfg_addr == 2'd0;
   assign tick     = state != IDLE && presc == PRESCALE_W'(PRESCALE_DIV - 1);
   assign end_ph   = tick && phase_cnt == DATA_W'(1);
   assign on_load  = on_time == '0 ? DATA_W'(1) : on_time;
   assign off_load = off_time == '0 ? DATA_W'(1) : off_time;
   assign busy     = state != IDLE;
   always_comb begin
      state_n = state;
      mode_n  = mode;
      presc_n = (state == IDLE || tick) ? '0 : presc + PRESCALE_W'(1);
      phase_n = (tick && phase_cnt > DATA_W'(1)) ? phase_cnt - DATA_W'(1) : phase_cnt;
      rpt_n   = rpt_left;
      done_n  = 1'b0;
      // A MODE write overrides any end-of-phase transition in the same cycle
      if (mode_wr) begin
         mode_n  = cfg.cfg_data[1:0];
         state_n = mode_n == 2'd0 ? IDLE : ON;
         presc_n = '0;
         phase_n = mode_n == 2'd0 ? '0 : on_load;
         rpt_n   = mode_n == 2'd0 ? '0 : rpt_reg;
      end else if (end_ph && state == ON) begin
         state_n = OFF;
         phase_n = off_load;
      end else if (end_ph && rpt_left != DATA_W'(1)) begin
         state_n = ON;
         phase_n = on_load;
         rpt_n   = rpt_left == '0 ? '0 : rpt_left - DATA_W'(1);
      end else if (end_ph) begin
         state_n = IDLE;
         phase_n = '0;
         rpt_n   = '0;
         done_n  = 1'b1;
      end
      led_r_n = state_n == ON;
      led_g_n = (state_n == ON && mode_n == 2'd2) || (state_n == OFF && mode_n == 2'd1);
   end
   always_ff @(posedge xclk or negedge sys_rst) begin
      if (!sys_rst) begin
         state     <= IDLE;
         mode      <= '0;
         presc     <= '0;
         phase_cnt <= '0;
         rpt_left  <= '0;
         done      <= 1'b0;
         led_r     <= 1'b0;
         led_g     <= 1'b0;
      end else begin
         state     <= state_n;
         mode      <= mode_n;
         presc     <= presc_n;
         phase_cnt <= phase_n;
         rpt_left  <= rpt_n;
         done      <= done_n;
         led_r     <= led_r_n;
         led_g     <= led_g_n;
      end
   end
   always_ff @(posedge xclk or negedge sys_rst) begin
      if (!sys_rst) begin
         on_time  <= '0;
         off_time <= '0;
         rpt_reg  <= '0;
      end else if (cfg.cfg_wr) begin
         if (cfg.cfg_addr == 2'd1) on_time  <= cfg.cfg_data;
         if (cfg.cfg_addr == 2'd2) off_time <= cfg.cfg_data;
         if (cfg.cfg_addr == 2'd3) rpt_reg  <= cfg.cfg_data;
      end
   end
endmodule

// File: tb/tb_led_seq_ctl.sv
// tb_led_seq_ctl: directed checks of the LED sequencer with a 4-cycle time unit.
module tb_led_seq_ctl;
   logic xclk = 1'b0;
   logic sys_rst = 1'b0;
   logic led_r, led_g, busy, done;
   logic [7:0] rpt_left;
   int vecs = 0;
   int errs = 0;
   led_seq_ctl_if #(.DATA_W(8)) bus();
   led_seq_ctl #(.PRESCALE_DIV(4), .PRESCALE_W(16), .DATA_W(8)) dut (
      .xclk(xclk), .sys_rst(sys_rst), .cfg(bus),
      .led_r(led_r), .led_g(led_g), .busy(busy), .done(done), .rpt_left(rpt_left)
   );
   always #5 xclk = ~xclk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // outputs packed as {led_r, led_g, busy, done, rpt_left}
   function automatic logic [31:0] outs();
      return {20'd0, led_r, led_g, busy, done, rpt_left};
   endfunction
   function automatic logic [31:0] pk(input bit r, input bit g, input bit b, input bit d, input int rpt);
      return {20'd0, r, g, b, d, 8'(rpt)};
   endfunction
   task automatic cyc(input int n);
      repeat (n) @(negedge xclk);
   endtask
   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      bus.cfg_wr = 1'b1;
      bus.cfg_addr = a;
      bus.cfg_data = d;
      @(negedge xclk);
      bus.cfg_wr = 1'b0;
   endtask
   task automatic run(input string tag, input int n, input bit r, input bit g, input bit b, input int rpt);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s[%0d]", tag, i), outs(), pk(r, g, b, 1'b0, rpt));
         @(negedge xclk);
      end
   endtask
   initial begin
      bus.cfg_wr = 1'b0;
      bus.cfg_addr = 2'd0;
      bus.cfg_data = 8'd0;
      @(negedge xclk);
      // 1: reset held while writes arrive
      wr(2'd1, 8'd3);
      wr(2'd0, 8'd1);
      chk("rst_hold", outs(), pk(0, 0, 0, 0, 0));
      wr(2'd0, 8'd2);
      chk("rst_hold2", outs(), pk(0, 0, 0, 0, 0));
      sys_rst = 1'b1;
      cyc(2);
      chk("rst_rel", outs(), pk(0, 0, 0, 0, 0));
      // 2: ALT, two repeats
      wr(2'd1, 8'd2);
      wr(2'd2, 8'd1);
      wr(2'd3, 8'd2);
      chk("reg_wr_idle", outs(), pk(0, 0, 0, 0, 0));
      wr(2'd0, 8'd1);
      run("alt_on1", 8, 1, 0, 1, 2);
      run("alt_off1", 4, 0, 1, 1, 2);
      run("alt_on2", 8, 1, 0, 1, 1);
      run("alt_off2", 4, 0, 1, 1, 1);
      chk("alt_done", outs(), pk(0, 0, 0, 1, 0));
      cyc(1);
      chk("alt_done_end", outs(), pk(0, 0, 0, 0, 0));
      // 3: SYNC continuous, then stop
      wr(2'd3, 8'd0);
      wr(2'd1, 8'd1);
      wr(2'd2, 8'd1);
      wr(2'd0, 8'd2);
      for (int p = 0; p < 10; p++) begin
         run($sformatf("sync_on%0d", p), 4, 1, 1, 1, 0);
         run($sformatf("sync_off%0d", p), 4, 0, 0, 1, 0);
      end
      wr(2'd0, 8'd0);
      run("sync_stop", 3, 0, 0, 0, 0);
      // 4: zero times, RED, one repeat
      wr(2'd1, 8'd0);
      wr(2'd2, 8'd0);
      wr(2'd3, 8'd1);
      wr(2'd0, 8'd3);
      run("red_on", 4, 1, 0, 1, 1);
      run("red_off", 4, 0, 0, 1, 1);
      chk("red_done", outs(), pk(0, 0, 0, 1, 0));
      cyc(1);
      chk("red_idle", outs(), pk(0, 0, 0, 0, 0));
      // 5: ON_TIME rewritten mid-phase only affects the next ON load
      wr(2'd1, 8'd2);
      wr(2'd2, 8'd1);
      wr(2'd3, 8'd0);
      wr(2'd0, 8'd1);
      wr(2'd1, 8'd5);
      run("upd_on1", 7, 1, 0, 1, 0);
      run("upd_off1", 4, 0, 1, 1, 0);
      run("upd_on2", 20, 1, 0, 1, 0);
      chk("upd_off2", outs(), pk(0, 1, 1, 0, 0));
      wr(2'd0, 8'd0);
      chk("upd_stop", outs(), pk(0, 0, 0, 0, 0));
      // 6: MODE write on the end-of-phase cycle, then async reset mid-OFF
      wr(2'd1, 8'd1);
      wr(2'd2, 8'd1);
      wr(2'd0, 8'd2);
      chk("race_on", outs(), pk(1, 1, 1, 0, 0));
      cyc(3);
      wr(2'd0, 8'd3);
      run("race_restart", 4, 1, 0, 1, 0);
      run("race_off", 4, 0, 0, 1, 0);
      run("race_on2", 4, 1, 0, 1, 0);
      chk("race_off2", outs(), pk(0, 0, 1, 0, 0));
      cyc(1);
      #2 sys_rst = 1'b0;
      #1 chk("async_rst", outs(), pk(0, 0, 0, 0, 0));
      @(negedge xclk);
      sys_rst = 1'b1;
      cyc(2);
      chk("post_rst", outs(), pk(0, 0, 0, 0, 0));
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
